store_write_unit: RTL and testbench
===================================

STORE_WRITE_UNIT -- requirements
Module: store_write_unit

Interface
REQ-001 SHALL have parameter SPLIT_MISALIGNED, default 1; 1 = word-crossing stores split into two bus writes, 0 = word-crossing stores rejected with error.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_storeValid  input  1  store request valid.
REQ-006 o_storeReady  output  1  unit can accept a request.
REQ-007 i_addr  input  32  byte address of store.
REQ-008 i_writeData  input  32  store data, right-justified.
REQ-009 i_memSize  input  2  00 word, 01 halfword, 10/11 byte (same encoding as the load-extend path).
REQ-010 o_memAddr  output  32  word-aligned bus address, bits [1:0] always 00.
REQ-011 o_memWriteData  output  32  lane-aligned write data.
REQ-012 o_byteEnable  output  4  per-byte write strobe; bit n covers bits [8n+7:8n].
REQ-013 o_memWrite  output  1  bus write request.
REQ-014 i_memAck  input  1  bus accepts the current write.
REQ-015 o_storeDone  output  1  one-cycle pulse when the store has fully completed.
REQ-016 o_misalignErr  output  1  one-cycle pulse when a word-crossing store is rejected (SPLIT_MISALIGNED=0 only).

Function
REQ-017 SHALL implement states IDLE, WR1, WR2, DONE, ERR; o_storeReady = (state==IDLE), combinational.
REQ-018 SHALL latch i_addr, i_writeData and i_memSize on the edge where i_storeValid && o_storeReady; i_storeValid is ignored in all other states.
REQ-019 Base mask SHALL be 0001 for byte, 0011 for half, 1111 for word; with off = i_addr[1:0]: mask8 = base << off (8 bits) and data64 = {32'h0, data} << (8*off).
REQ-020 Access 1 SHALL use address {addr[31:2],2'b00}, enable mask8[3:0], data data64[31:0].
REQ-021 Access 2 SHALL be needed iff mask8[7:4] != 0 and SHALL use address {addr[31:2],2'b00}+4 (mod 2^32), enable mask8[7:4], data data64[63:32].
REQ-022 Byte lanes with enable 0 SHALL carry data 0.
REQ-023 IDLE->WR1 on accept, unless access 2 is needed and SPLIT_MISALIGNED=0, in which case IDLE->ERR.
REQ-024 In WR1/WR2, o_memWrite SHALL be 1 and o_memAddr/o_memWriteData/o_byteEnable SHALL be held stable until i_memAck.
REQ-025 WR1 + i_memAck SHALL go to WR2 if access 2 is needed, else DONE; WR2 + i_memAck SHALL go to DONE.
REQ-026 DONE SHALL drive o_storeDone=1 for exactly one cycle, then return to IDLE.
REQ-027 ERR SHALL drive o_misalignErr=1 for exactly one cycle with no bus write, then return to IDLE.
REQ-028 Minimum latency: accept at edge N; o_memWrite high in cycle N+1; i_memAck sampled at edge N+1 (same cycle) gives o_storeDone in cycle N+2 for an aligned store, N+3 for a split store.
REQ-029 In IDLE, DONE and ERR, o_memWrite and o_byteEnable SHALL be 0; i_memAck outside WR1/WR2 SHALL be ignored.

Reset
REQ-030 i_rst SHALL immediately force state IDLE and set o_memWrite, o_byteEnable, o_memAddr, o_memWriteData, o_storeDone and o_misalignErr to 0; o_storeReady SHALL be 1.
REQ-031 Reset asserted during WR1/WR2 SHALL abandon the store without o_storeDone, and o_memWrite SHALL drop asynchronously.

Verification
REQ-032 sw: addr 0x100, data 0x11223344, size 00 -> one write: addr 0x100, be 1111, data 0x11223344; then o_storeDone pulse.
REQ-033 sb / sh: sb addr 0x103, data 0xAABBCCDD, size 10 -> addr 0x100, be 1000, data 0xDD000000. sh addr 0x202, data 0x0000BEEF, size 01 -> addr 0x200, be 1100, data 0xBEEF0000.
REQ-034 Split store (SPLIT_MISALIGNED=1): sw addr 0x301, data 0x11223344 -> write 1: addr 0x300, be 1110, data 0x22334400; write 2: addr 0x304, be 0001, data 0x00000011; one o_storeDone pulse.
REQ-035 Wrap: sh addr 0xFFFFFFFF, data 0x0000ABCD -> write 1: addr 0xFFFFFFFC, be 1000, data 0xCD000000; write 2: addr 0x00000000, be 0001, data 0x000000AB.
REQ-036 Stalled bus: i_memAck held low 3 cycles while i_storeValid toggles -> outputs stable, o_storeReady 0, no new request latched.
REQ-037 Error / reset: with SPLIT_MISALIGNED=0, sh addr 0x3 -> no o_memWrite, o_misalignErr for 1 cycle, then o_storeReady=1. Separately, i_rst asserted mid-WR2 -> o_memWrite 0 at once and no o_storeDone.

Source files
------------

// File: rtl/store_write_unit.sv
// Store write unit: lane-aligns store data, builds byte strobes and drives
// one or two word-aligned bus writes per store request.
module store_write_unit #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_storeValid,
    output logic        o_storeReady,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    input  logic [1:0]  i_memSize,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWriteData,
    output logic [3:0]  o_byteEnable,
    output logic        o_memWrite,
    input  logic        i_memAck,
    output logic        o_storeDone,
    output logic        o_misalignErr
);

    typedef enum logic [2:0] {
        IDLE,
        WR1,
        WR2,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b1111;
            2'b01:   m = 4'b0011;
            default: m = 4'b0001;
        endcase
        return m;
    endfunction

    logic        accept;
    logic        in_split;
    logic [3:0]  base;
    logic [7:0]  mask8;
    logic [31:0] data_m;
    logic [63:0] data64;
    logic        split;
    logic [31:0] word_addr;

    assign accept = i_storeValid && (state == IDLE);

    // A request crosses a word when its last byte lands past lane 3.
    assign in_split = ((i_memSize == 2'b00) && (i_addr[1:0] != 2'b00))
                   || ((i_memSize == 2'b01) && (i_addr[1:0] == 2'b11));

    assign base   = base_mask(size_q);
    assign mask8  = {4'h0, base} << addr_q[1:0];
    assign data_m = data_q & {{8{base[3]}}, {8{base[2]}},
                              {8{base[1]}}, {8{base[0]}}};
    assign data64 = {32'h0, data_m} << {addr_q[1:0], 3'b000};
    assign split  = |mask8[7:4];
    assign word_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= 32'h0;
            data_q <= 32'h0;
            size_q <= 2'b00;
        end else if (accept) begin
            addr_q <= i_addr;
            data_q <= i_writeData;
            size_q <= i_memSize;
        end
    end

    always_comb begin
        state_next     = state;
        o_storeReady   = 1'b0;
        o_memWrite     = 1'b0;
        o_memAddr      = 32'h0;
        o_memWriteData = 32'h0;
        o_byteEnable   = 4'h0;
        o_storeDone    = 1'b0;
        o_misalignErr  = 1'b0;
        unique case (state)
            IDLE: begin
                o_storeReady = 1'b1;
                if (i_storeValid) begin
                    if (in_split && (SPLIT_MISALIGNED == 0)) begin
                        state_next = ERR;
                    end else begin
                        state_next = WR1;
                    end
                end
            end
            WR1: begin
                o_memWrite     = 1'b1;
                o_memAddr      = word_addr;
                o_byteEnable   = mask8[3:0];
                o_memWriteData = data64[31:0];
                if (i_memAck) begin
                    state_next = split ? WR2 : DONE;
                end
            end
            WR2: begin
                o_memWrite     = 1'b1;
                o_memAddr      = word_addr + 32'd4;
                o_byteEnable   = mask8[7:4];
                o_memWriteData = data64[63:32];
                if (i_memAck) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_storeDone = 1'b1;
                state_next  = IDLE;
            end
            ERR: begin
                o_misalignErr = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_write_unit.sv
// Bench for store_write_unit: directed table, byte-level reference model
// with random stores, misalign rejection and mid-store reset.
module tb_store_write_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        valid0;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        ack;
    logic        ack0;

    logic        ready,  ready0;
    logic [31:0] maddr,  maddr0;
    logic [31:0] mdata,  mdata0;
    logic [3:0]  be,     be0;
    logic        mwrite, mwrite0;
    logic        done,   done0;
    logic        err,    err0;

    int nvec = 0;
    int nerr = 0;

    store_write_unit #(.SPLIT_MISALIGNED(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_storeValid(valid), .o_storeReady(ready),
        .i_addr(addr), .i_writeData(wdata), .i_memSize(size),
        .o_memAddr(maddr), .o_memWriteData(mdata),
        .o_byteEnable(be), .o_memWrite(mwrite),
        .i_memAck(ack), .o_storeDone(done), .o_misalignErr(err)
    );

    store_write_unit #(.SPLIT_MISALIGNED(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_storeValid(valid0), .o_storeReady(ready0),
        .i_addr(addr), .i_writeData(wdata), .i_memSize(size),
        .o_memAddr(maddr0), .o_memWriteData(mdata0),
        .o_byteEnable(be0), .o_memWrite(mwrite0),
        .i_memAck(ack0), .o_storeDone(done0), .o_misalignErr(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected bus writes, built byte by byte from the store's footprint.
    task automatic model(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, output int nw,
                         output logic [31:0] a1, output logic [3:0] b1,
                         output logic [31:0] d1, output logic [31:0] a2,
                         output logic [3:0] b2, output logic [31:0] d2);
        int n;
        n  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        nw = 0;
        a1 = '0; b1 = '0; d1 = '0;
        a2 = '0; b2 = '0; d2 = '0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ba;
            logic [31:0] w;
            int ln;
            ba = a + i;
            w  = {ba[31:2], 2'b00};
            ln = int'(ba[1:0]);
            if (nw == 0 || (nw == 1 && w != a1)) nw++;
            if (nw == 1) begin
                a1 = w;
                b1[ln] = 1'b1;
                d1[8*ln +: 8] = d[8*i +: 8];
            end else begin
                a2 = w;
                b2[ln] = 1'b1;
                d2[8*ln +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic chk_wr(input string nm, input logic [31:0] ea,
                          input logic [3:0] eb, input logic [31:0] ed);
        chk({nm, ".mwrite"}, {31'h0, mwrite}, 32'h1);
        chk({nm, ".addr"}, maddr, ea);
        chk({nm, ".be"}, {28'h0, be}, {28'h0, eb});
        chk({nm, ".data"}, mdata, ed);
        chk({nm, ".ready"}, {31'h0, ready}, 32'h0);
    endtask

    // Entered and left at a negedge with the unit idle.
    task automatic run_store(input string nm, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] sz,
                             input int stall, input int nw,
                             input logic [31:0] a1, input logic [3:0] b1,
                             input logic [31:0] d1, input logic [31:0] a2,
                             input logic [3:0] b2, input logic [31:0] d2);
        chk({nm, ".idle_ready"}, {31'h0, ready}, 32'h1);
        valid = 1'b1; addr = a; wdata = d; size = sz; ack = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < nw; k++) begin
            for (int s = 0; s < stall; s++) begin
                chk_wr(nm, k == 0 ? a1 : a2, k == 0 ? b1 : b2,
                       k == 0 ? d1 : d2);
                valid = 1'($urandom);
                addr  = $urandom;
                wdata = $urandom;
                size  = 2'($urandom);
                @(negedge clk);
            end
            chk_wr(nm, k == 0 ? a1 : a2, k == 0 ? b1 : b2,
                   k == 0 ? d1 : d2);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            valid = 1'b0;
        end
        chk({nm, ".done"}, {31'h0, done}, 32'h1);
        chk({nm, ".done_mwrite"}, {31'h0, mwrite}, 32'h0);
        chk({nm, ".done_be"}, {28'h0, be}, 32'h0);
        @(negedge clk);
        chk({nm, ".done_pulse"}, {31'h0, done}, 32'h0);
        chk({nm, ".back_ready"}, {31'h0, ready}, 32'h1);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        int          stall;
        int          nw;
        logic [31:0] a1;
        logic [3:0]  b1;
        logic [31:0] d1;
        logic [31:0] a2;
        logic [3:0]  b2;
        logic [31:0] d2;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{"sw", 32'h100, 32'h11223344, 2'b00, 0, 1,
                  32'h100, 4'b1111, 32'h11223344, 32'h0, 4'h0, 32'h0};
        vt[1] = '{"sb", 32'h103, 32'hAABBCCDD, 2'b10, 0, 1,
                  32'h100, 4'b1000, 32'hDD000000, 32'h0, 4'h0, 32'h0};
        vt[2] = '{"sh", 32'h202, 32'h0000BEEF, 2'b01, 0, 1,
                  32'h200, 4'b1100, 32'hBEEF0000, 32'h0, 4'h0, 32'h0};
        vt[3] = '{"split", 32'h301, 32'h11223344, 2'b00, 0, 2,
                  32'h300, 4'b1110, 32'h22334400,
                  32'h304, 4'b0001, 32'h00000011};
        vt[4] = '{"wrap", 32'hFFFFFFFF, 32'h0000ABCD, 2'b01, 0, 2,
                  32'hFFFFFFFC, 4'b1000, 32'hCD000000,
                  32'h0, 4'b0001, 32'h000000AB};
        vt[5] = '{"stall", 32'h100, 32'h11223344, 2'b00, 3, 1,
                  32'h100, 4'b1111, 32'h11223344, 32'h0, 4'h0, 32'h0};
        vt[6] = '{"sb11", 32'h401, 32'h12345678, 2'b11, 1, 1,
                  32'h400, 4'b0010, 32'h00007800, 32'h0, 4'h0, 32'h0};

        rst = 1'b1; valid = 1'b0; valid0 = 1'b0;
        addr = '0; wdata = '0; size = '0; ack = 1'b0; ack0 = 1'b0;
        @(negedge clk);
        chk("rst.ready", {31'h0, ready}, 32'h1);
        chk("rst.mwrite", {31'h0, mwrite}, 32'h0);
        chk("rst.be", {28'h0, be}, 32'h0);
        chk("rst.addr", maddr, 32'h0);
        chk("rst.data", mdata, 32'h0);
        chk("rst.done", {31'h0, done}, 32'h0);
        chk("rst.err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_store(vt[i].nm, vt[i].a, vt[i].d, vt[i].sz, vt[i].stall,
                      vt[i].nw, vt[i].a1, vt[i].b1, vt[i].d1,
                      vt[i].a2, vt[i].b2, vt[i].d2);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rd, a1, d1, a2, d2;
            logic [1:0]  rs;
            logic [3:0]  b1, b2;
            int nw;
            ra = $urandom;
            if (i % 3 == 0) ra[1:0] = 2'b11;
            rd = $urandom;
            rs = 2'($urandom_range(0, 3));
            model(ra, rd, rs, nw, a1, b1, d1, a2, b2, d2);
            run_store("rand", ra, rd, rs, $urandom_range(0, 2), nw,
                      a1, b1, d1, a2, b2, d2);
        end

        // Word-crossing halfword rejected when splitting is disabled.
        chk("err.ready0", {31'h0, ready0}, 32'h1);
        valid0 = 1'b1; addr = 32'h3; wdata = 32'h1234; size = 2'b01;
        @(negedge clk);
        valid0 = 1'b0;
        chk("err.pulse", {31'h0, err0}, 32'h1);
        chk("err.mwrite", {31'h0, mwrite0}, 32'h0);
        chk("err.be", {28'h0, be0}, 32'h0);
        @(negedge clk);
        chk("err.pulse_end", {31'h0, err0}, 32'h0);
        chk("err.mwrite2", {31'h0, mwrite0}, 32'h0);
        chk("err.ready_back", {31'h0, ready0}, 32'h1);

        // Reset while the second half of a split store is on the bus.
        valid = 1'b1; addr = 32'h301; wdata = 32'h11223344; size = 2'b00;
        @(negedge clk);
        valid = 1'b0;
        chk_wr("rstwr1", 32'h300, 4'b1110, 32'h22334400);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk_wr("rstwr2", 32'h304, 4'b0001, 32'h00000011);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.mwrite", {31'h0, mwrite}, 32'h0);
        chk("rstmid.be", {28'h0, be}, 32'h0);
        chk("rstmid.addr", maddr, 32'h0);
        chk("rstmid.ready", {31'h0, ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid.no_done", {31'h0, done}, 32'h0);
            chk("rstmid.idle", {31'h0, ready}, 32'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
